mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 172 +++++++++++++++++
 tb/tb_mem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency SRAM and memory-mapped I/O responder for a 16-bit CPU.
// Strobes, completion strobe and returned data are all registered; reset aborts any access.
module mem_responder #(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR,
   input  logic        Req_Rd,
   input  logic        Req_Wr,
   input  logic [15:0] S,
   output logic [15:0] MDR_In,
   output logic        R,
   output logic        Busy,
   output logic [15:0] HEX_Data,
   output logic [19:0] ADDR,
   output logic [15:0] Data_to_SRAM,
   input  logic [15:0] Data_from_SRAM,
   output logic        SRAM_Drive,
   output logic        CE_N,
   output logic        OE_N,
   output logic        WE_N,
   output logic        UB_N,
   output logic        LB_N
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_ACCESS = 3'd1,
      WR_ACCESS = 3'd2,
      IO_DONE   = 3'd3,
      DONE      = 3'd4
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] mar_q, mar_d;
   logic [15:0] mdr_q, mdr_d;
   logic [15:0] mdr_in_q, mdr_in_d;
   logic [15:0] hex_q, hex_d;
   logic        r_q, r_d;
   logic        drive_q, drive_d;
   logic        ce_n_q, ce_n_d;
   logic        oe_n_q, oe_n_d;
   logic        we_n_q, we_n_d;
   logic        byte_n_q, byte_n_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mar_d    = mar_q;
      mdr_d    = mdr_q;
      mdr_in_d = mdr_in_q;
      hex_d    = hex_q;
      case (state_q)
         IDLE: begin
            if (Req_Wr || Req_Rd) begin
               mar_d = MAR;
               mdr_d = MDR;
               cnt_d = CNT_INIT;
               // I/O results are captured on the accept edge so they are valid while R is high
               if (MAR == IO_ADDR) begin
                  state_d = IO_DONE;
                  if (Req_Wr) begin
                     hex_d = MDR;
                  end else begin
                     mdr_in_d = S;
                  end
               end else if (Req_Wr) begin
                  state_d = WR_ACCESS;
               end else begin
                  state_d = RD_ACCESS;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD_ACCESS: begin
            if (cnt_q == 4'd0) begin
               mdr_in_d = Data_from_SRAM;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         WR_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         IO_DONE: state_d = IDLE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes are decoded from the next state so the registered pins line up with the state
   always_comb begin
      r_d      = 1'b0;
      drive_d  = 1'b0;
      ce_n_d   = 1'b1;
      oe_n_d   = 1'b1;
      we_n_d   = 1'b1;
      byte_n_d = 1'b1;
      case (state_d)
         RD_ACCESS: begin
            ce_n_d   = 1'b0;
            oe_n_d   = 1'b0;
            byte_n_d = 1'b0;
         end
         WR_ACCESS: begin
            ce_n_d   = 1'b0;
            we_n_d   = 1'b0;
            byte_n_d = 1'b0;
            drive_d  = 1'b1;
         end
         IO_DONE: r_d = 1'b1;
         DONE:    r_d = 1'b1;
         default: r_d = 1'b0;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         mar_q    <= 16'h0000;
         mdr_q    <= 16'h0000;
         mdr_in_q <= 16'h0000;
         hex_q    <= 16'h0000;
         r_q      <= 1'b0;
         drive_q  <= 1'b0;
         ce_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
         byte_n_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mar_q    <= mar_d;
         mdr_q    <= mdr_d;
         mdr_in_q <= mdr_in_d;
         hex_q    <= hex_d;
         r_q      <= r_d;
         drive_q  <= drive_d;
         ce_n_q   <= ce_n_d;
         oe_n_q   <= oe_n_d;
         we_n_q   <= we_n_d;
         byte_n_q <= byte_n_d;
      end
   end

   assign MDR_In       = mdr_in_q;
   assign R            = r_q;
   assign Busy         = (state_q != IDLE);
   assign HEX_Data     = hex_q;
   assign ADDR         = {4'h0, mar_q};
   assign Data_to_SRAM = mdr_q;
   assign SRAM_Drive   = drive_q;
   assign CE_N         = ce_n_q;
   assign OE_N         = oe_n_q;
   assign WE_N         = we_n_q;
   assign UB_N         = byte_n_q;
   assign LB_N         = byte_n_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: scoreboard of expected completions (cycle and data),
// behavioural SRAM, directed SRAM / I/O / priority / hold / reset-abort scenarios.
module tb_mem_responder;

   localparam int W = 2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] MAR, MDR, S;
   logic        Req_Rd, Req_Wr;
   logic [15:0] MDR_In, HEX_Data, Data_to_SRAM, Data_from_SRAM;
   logic        R, Busy, SRAM_Drive, CE_N, OE_N, WE_N, UB_N, LB_N;
   logic [19:0] ADDR;

   mem_responder #(.WAIT_CYCLES(W), .IO_ADDR(16'hFFFF)) dut (
      .Clk(Clk), .Reset(Reset), .MAR(MAR), .MDR(MDR), .Req_Rd(Req_Rd), .Req_Wr(Req_Wr),
      .S(S), .MDR_In(MDR_In), .R(R), .Busy(Busy), .HEX_Data(HEX_Data), .ADDR(ADDR),
      .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM), .SRAM_Drive(SRAM_Drive),
      .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int          cyc;
      bit          hex;
      logic [15:0] val;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] exp_mem [logic [15:0]];
   logic [15:0] mdr_model = 16'h0000;
   logic [15:0] hex_model = 16'h0000;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc = 0;
   int          ce_cnt = 0, oe_cnt = 0, we_cnt = 0, drv_cnt = 0, r_cnt = 0;

   // behavioural SRAM, with a preload port used only while Reset is held
   logic [15:0] mem [0:255];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_a  = 8'h00;
   logic [15:0] pre_d  = 16'h0000;

   always @(posedge Clk) begin
      if (pre_we) mem[pre_a] <= pre_d;
      else if (!CE_N && !WE_N && SRAM_Drive) mem[ADDR[7:0]] <= Data_to_SRAM;
   end
   assign Data_from_SRAM = mem[ADDR[7:0]];

   always @(posedge Clk) cyc <= cyc + 1;

   // per-cycle activity counters sampled away from the active edge
   always @(negedge Clk) begin
      if (CE_N === 1'b0 && UB_N === 1'b0 && LB_N === 1'b0) ce_cnt <= ce_cnt + 1;
      if (OE_N === 1'b0) oe_cnt <= oe_cnt + 1;
      if (WE_N === 1'b0) we_cnt <= we_cnt + 1;
      if (SRAM_Drive === 1'b1) drv_cnt <= drv_cnt + 1;
      if (R === 1'b1) r_cnt <= r_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // wait for R while checking latched address/data stability, then pop and compare
   task automatic wait_r(input logic [15:0] mar, input logic [15:0] mdr);
      int   k;
      exp_t e;
      k = 0;
      while (R !== 1'b1 && k < 40) begin
         if (CE_N === 1'b0) check("addr_stable", ADDR, {4'h0, mar});
         if (WE_N === 1'b0) check("data_stable", Data_to_SRAM, mdr);
         @(negedge Clk);
         k++;
      end
      if (R !== 1'b1) begin
         check("r_timeout", 32'd0, 32'd1);
      end else if (sb.size() == 0) begin
         check("sb_empty_on_r", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("r_cycle", cyc, e.cyc);
         if (e.hex) check("hex_data", HEX_Data, e.val);
         else       check("mdr_in", MDR_In, e.val);
      end
   endtask

   task automatic access(input bit rd, input bit wr, input logic [15:0] mar,
                         input logic [15:0] mdr, input bit chg, input bit no_wait);
      bit io;
      int c0, o0, w0, d0, r0;
      exp_t e;
      if (!no_wait) @(negedge Clk);
      Req_Rd = rd; Req_Wr = wr; MAR = mar; MDR = mdr;
      io = (mar == 16'hFFFF);
      if (io) begin
         if (wr) hex_model = mdr;
         else    mdr_model = S;
      end else if (wr) begin
         exp_mem[mar] = mdr;
      end else begin
         mdr_model = exp_mem[mar];
      end
      e.cyc = cyc + 1 + (io ? 0 : W);
      e.hex = io && wr;
      e.val = e.hex ? hex_model : mdr_model;
      sb.push_back(e);
      c0 = ce_cnt; o0 = oe_cnt; w0 = we_cnt; d0 = drv_cnt; r0 = r_cnt;
      @(negedge Clk);
      Req_Rd = 1'b0; Req_Wr = 1'b0;
      if (chg) begin MAR = ~mar; MDR = ~mdr; end
      wait_r(mar, mdr);
      check("ce_cycles",    ce_cnt - c0,  io ? 0 : W);
      check("oe_cycles",    oe_cnt - o0,  (io || wr) ? 0 : W);
      check("we_cycles",    we_cnt - w0,  (!io && wr) ? W : 0);
      check("drive_cycles", drv_cnt - d0, (!io && wr) ? W : 0);
      @(negedge Clk);
      check("r_one_pulse", r_cnt - r0, 1);
      check("idle_after", Busy, 1'b0);
   endtask

   initial begin
      int r0;
      exp_t e;
      Reset = 1'b1; Req_Rd = 1'b0; Req_Wr = 1'b0;
      MAR = 16'h0000; MDR = 16'h0000; S = 16'h0000;
      pre_we = 1'b1; pre_a = 8'h42; pre_d = 16'h1234;
      exp_mem[16'h0042] = 16'h1234;
      repeat (2) @(negedge Clk);
      pre_we = 1'b0;
      check("rst_r", R, 1'b0);
      check("rst_busy", Busy, 1'b0);
      check("rst_drive", SRAM_Drive, 1'b0);
      check("rst_strobes", {CE_N, OE_N, WE_N, UB_N, LB_N}, 5'b11111);
      check("rst_mdr_in", MDR_In, 16'h0000);
      check("rst_hex", HEX_Data, 16'h0000);
      check("rst_addr", ADDR, 20'h00000);
      check("rst_dts", Data_to_SRAM, 16'h0000);
      @(negedge Clk);
      Reset = 1'b0;

      access(1'b1, 1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0);
      access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0);
      check("wr_addr_latched", ADDR, 20'h00010);
      access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
      access(1'b0, 1'b1, 16'hFFFF, 16'h00A5, 1'b0, 1'b0);
      S = 16'h5A5A;
      access(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
      check("hex_hold", HEX_Data, 16'h00A5);
      access(1'b1, 1'b1, 16'h0077, 16'h1357, 1'b1, 1'b0);
      access(1'b1, 1'b0, 16'h0077, 16'h0000, 1'b0, 1'b0);

      // request held across DONE -> two back-to-back reads
      @(negedge Clk);
      Req_Rd = 1'b1; MAR = 16'h0042;
      mdr_model = exp_mem[16'h0042];
      e.hex = 1'b0; e.val = mdr_model;
      e.cyc = cyc + 1 + W;         sb.push_back(e);
      e.cyc = cyc + 1 + W + W + 2; sb.push_back(e);
      r0 = r_cnt;
      @(negedge Clk);
      wait_r(16'h0042, 16'h0000);
      @(negedge Clk);
      wait_r(16'h0042, 16'h0000);
      Req_Rd = 1'b0;
      @(negedge Clk);
      check("held_r_pulses", r_cnt - r0, 2);

      // reset during the second RD_ACCESS cycle aborts without R
      @(negedge Clk);
      Req_Rd = 1'b1; MAR = 16'h0042;
      @(negedge Clk);
      Req_Rd = 1'b0;
      @(posedge Clk);
      #2 Reset = 1'b1;
      r0 = r_cnt;
      #1;
      check("abort_strobes", {CE_N, OE_N, WE_N, UB_N, LB_N}, 5'b11111);
      check("abort_busy", Busy, 1'b0);
      check("abort_mdr_in", MDR_In, 16'h0000);
      check("abort_hex", HEX_Data, 16'h0000);
      repeat (3) @(negedge Clk);
      check("abort_no_r", r_cnt - r0, 0);
      mdr_model = 16'h0000; hex_model = 16'h0000;
      Reset = 1'b0;
      access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
